// File: rtl/mips_multicycle.sv
// Multi-cycle MIPS core (add/sub/and/or/slt, addi/andi/ori/lw/sw/beq/j) with a single
// unified req/ready memory port; a state machine sequences each instruction.
module mips_multicycle #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic              memReq_out,
    output logic              memWe_out,
    output logic [ADDR_W-1:0] memAddr_out,
    output logic [31:0]       memWData_out,
    input  logic [31:0]       memRData_in,
    input  logic              memReady_in,
    output logic [31:0]       pc_out,
    output logic              halted_out,
    output logic [31:0]       retired_out
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] mdr_q, mdr_d;
    logic [31:0] retired_q, retired_d;

    logic [31:0] rf_q [32];
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] imm_sext, imm_zext, alu_b, alu_y, br_off;
    logic        is_r, legal;

    assign op       = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign funct    = ir_q[5:0];
    assign imm      = ir_q[15:0];
    assign is_r     = (op == OP_R);
    assign imm_sext = {{16{imm[15]}}, imm};
    assign imm_zext = {16'h0000, imm};
    assign br_off   = {imm_sext[29:0], 2'b00};

    always_comb begin
        legal = 1'b0;
        case (op)
            OP_R:    legal = (funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT});
            OP_J, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    // Logical immediates are zero-extended; everything else sign-extends.
    always_comb begin
        alu_b = is_r ? b_q : (((op == OP_ANDI) || (op == OP_ORI)) ? imm_zext : imm_sext);
        alu_y = a_q + alu_b;
        if (is_r) begin
            case (funct)
                F_SUB:   alu_y = a_q - alu_b;
                F_AND:   alu_y = a_q & alu_b;
                F_OR:    alu_y = a_q | alu_b;
                F_SLT:   alu_y = ($signed(a_q) < $signed(alu_b)) ? 32'd1 : 32'd0;
                default: alu_y = a_q + alu_b;
            endcase
        end else if (op == OP_ANDI) begin
            alu_y = a_q & alu_b;
        end else if (op == OP_ORI) begin
            alu_y = a_q | alu_b;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_d     = alu_q;
        mdr_d     = mdr_q;
        retired_d = retired_q;
        rf_we     = 1'b0;
        rf_waddr  = is_r ? rd : rt;
        rf_wdata  = (op == OP_LW) ? mdr_q : alu_q;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (memReady_in) begin
                    ir_d    = memRData_in;
                    pc_d    = pc_q + 32'd4;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d = (rs == 5'd0) ? 32'd0 : rf_q[rs];
                b_d = (rt == 5'd0) ? 32'd0 : rf_q[rt];
                if (op == OP_J) begin
                    pc_d      = {pc_q[31:28], ir_q[25:0], 2'b00};
                    retired_d = retired_q + 32'd1;
                    state_d   = S_FETCH;
                end else if (!legal) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_d = alu_y;
                if (op == OP_BEQ) begin
                    if (a_q == b_q) pc_d = pc_q + br_off;
                    retired_d = retired_q + 32'd1;
                    state_d   = S_FETCH;
                end else if ((op == OP_LW) || (op == OP_SW)) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (memReady_in) begin
                    if (op == OP_SW) begin
                        retired_d = retired_q + 32'd1;
                        state_d   = S_FETCH;
                    end else begin
                        mdr_d   = memRData_in;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we     = (rf_waddr != 5'd0);
                retired_d = retired_q + 32'd1;
                state_d   = S_FETCH;
            end
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_q     <= '0;
            mdr_q     <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_q     <= alu_d;
            mdr_q     <= mdr_d;
            retired_q <= retired_d;
        end
    end

    // Register file is deliberately left uninitialised by reset.
    always_ff @(posedge clk) begin
        if (rf_we) rf_q[rf_waddr] <= rf_wdata;
    end

    // Port signals decode straight from state so an async reset clears them at once.
    logic [31:0] addr_full;
    logic        unused_bits;

    assign addr_full    = (state_q == S_FETCH) ? pc_q : ((state_q == S_MEM) ? alu_q : 32'd0);
    assign memReq_out   = (state_q == S_FETCH) || (state_q == S_MEM);
    assign memWe_out    = (state_q == S_MEM) && (op == OP_SW);
    assign memAddr_out  = {addr_full[ADDR_W-1:2], 2'b00};
    assign memWData_out = memWe_out ? b_q : 32'd0;
    assign pc_out       = pc_q;
    assign halted_out   = (state_q == S_HALT);
    assign retired_out  = retired_q;
    assign unused_bits  = ^{addr_full, ir_q[10:6]};

endmodule

// File: tb/tb_mips_multicycle.sv
// Bench for mips_multicycle: memory model with programmable wait states, store scoreboard
// checked by a separate monitor, plus directed latency/PC/halt/reset checks.
module tb_mips_multicycle;

    localparam logic [5:0] OP_BEQ = 6'h04, OP_ADDI = 6'h08, OP_ANDI = 6'h0C, OP_ORI = 6'h0D;
    localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memReq_out, memWe_out, halted_out;
    logic [31:0] memAddr_out, memWData_out, pc_out, retired_out;
    logic [31:0] memRData_in = 32'd0;
    logic        memReady_in = 1'b0;

    mips_multicycle dut (
        .clk          (clk),
        .reset        (reset),
        .memReq_out   (memReq_out),
        .memWe_out    (memWe_out),
        .memAddr_out  (memAddr_out),
        .memWData_out (memWData_out),
        .memRData_in  (memRData_in),
        .memReady_in  (memReady_in),
        .pc_out       (pc_out),
        .halted_out   (halted_out),
        .retired_out  (retired_out)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    int waits = 0;
    int test_id = 0;
    int pidx = 0;

    logic [31:0] prog [256];
    logic [31:0] dmem [256];
    int          dtag [256];

    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    wr_t sb [$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] f, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'h00, f};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] t);
        return {6'h02, t};
    endfunction

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        logic [7:0] idx;
        idx = a[9:2];
        return (dtag[idx] == test_id) ? dmem[idx] : prog[idx];
    endfunction

    task automatic emit(input logic [31:0] w);
        prog[pidx] = w;
        pidx++;
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    // Memory responder (after the rising edge) and store monitor (falling edge).
    initial begin
        int wcnt;
        wr_t e;
        wcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (reset && memReq_out) begin
                if (wcnt >= waits) begin
                    memReady_in = 1'b1;
                    memRData_in = mem_read(memAddr_out);
                    wcnt = 0;
                end else begin
                    memReady_in = 1'b0;
                    memRData_in = 32'hDEAD_BEEF;
                    wcnt++;
                end
            end else begin
                memReady_in = 1'b0;
                wcnt = 0;
            end
            @(negedge clk);
            if (reset && memReq_out && memWe_out) begin
                if (sb.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL unexpected_write: actual addr=%h data=%h required none", memAddr_out, memWData_out);
                end else begin
                    e = sb[0];
                    check("wr_addr", memAddr_out, e.addr);
                    check("wr_data", memWData_out, e.data);
                    if (memReady_in) begin
                        void'(sb.pop_front());
                        dmem[memAddr_out[9:2]] = memWData_out;
                        dtag[memAddr_out[9:2]] = test_id;
                    end
                end
            end
        end
    end

    task automatic wait_retired(input int n, output int c, output logic [31:0] p);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (retired_out == n) begin
                ok = 1'b1;
                break;
            end
        end
        c = cyc;
        p = pc_out;
        if (!ok) begin
            tests++;
            failed++;
            $display("FAIL retire_timeout: actual retired=%0d required=%0d", retired_out, n);
        end
    endtask

    task automatic wait_halt();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (halted_out) begin
                ok = 1'b1;
                break;
            end
        end
        check("halted", {31'd0, ok}, 32'd1);
    endtask

    task automatic new_program(input int w);
        reset = 1'b0;
        waits = w;
        test_id++;
        pidx = 0;
        for (int i = 0; i < 256; i++) prog[i] = 32'd0;
    endtask

    task automatic release_reset(output int c0);
        @(negedge clk);
        reset = 1'b1;
        c0 = cyc + 1;
    endtask

    int          rc [0:40];
    logic [31:0] pcs [0:40];

    initial begin
        int bad;
        int c0;
        #1;
        check("rst_req", {31'd0, memReq_out}, 32'd0);
        check("rst_we", {31'd0, memWe_out}, 32'd0);
        check("rst_addr", memAddr_out, 32'd0);
        check("rst_wdata", memWData_out, 32'd0);
        check("rst_pc", pc_out, 32'd0);
        check("rst_retired", retired_out, 32'd0);
        check("rst_halted", {31'd0, halted_out}, 32'd0);

        // Program A: zero-wait ALU / load-store / branch / jump / halt.
        new_program(0);
        emit(enc_i(OP_ADDI, 0, 1, 16'd5));
        emit(enc_i(OP_ADDI, 0, 2, 16'd7));
        emit(enc_r(F_ADD, 1, 2, 3));
        emit(enc_i(OP_SW, 0, 3, 16'h0200));  expect_wr(32'h200, 32'd12);
        emit(enc_i(OP_LW, 0, 4, 16'h0200));
        emit(enc_i(OP_SW, 0, 4, 16'h0204));  expect_wr(32'h204, 32'd12);
        emit(enc_i(OP_ADDI, 0, 0, 16'd5));
        emit(enc_i(OP_SW, 0, 0, 16'h0208));  expect_wr(32'h208, 32'd0);
        emit(enc_i(OP_ORI, 0, 5, 16'hFFFF));
        emit(enc_i(OP_SW, 0, 5, 16'h020C));  expect_wr(32'h20C, 32'h0000_FFFF);
        emit(enc_i(OP_ADDI, 0, 5, 16'hFFFF));
        emit(enc_i(OP_SW, 0, 5, 16'h0210));  expect_wr(32'h210, 32'hFFFF_FFFF);
        emit(enc_i(OP_ADDI, 0, 6, 16'd1));
        emit(enc_r(F_SLT, 5, 6, 7));
        emit(enc_i(OP_SW, 0, 7, 16'h0214));  expect_wr(32'h214, 32'd1);
        emit(enc_r(F_SLT, 6, 5, 8));
        emit(enc_i(OP_SW, 0, 8, 16'h0218));  expect_wr(32'h218, 32'd0);
        emit(enc_r(F_SUB, 1, 2, 9));
        emit(enc_i(OP_SW, 0, 9, 16'h021C));  expect_wr(32'h21C, 32'hFFFF_FFFE);
        emit(enc_i(OP_ANDI, 5, 12, 16'h8001));
        emit(enc_i(OP_SW, 0, 12, 16'h0220)); expect_wr(32'h220, 32'h0000_8001);
        emit(enc_r(F_OR, 1, 12, 11));
        emit(enc_i(OP_SW, 0, 11, 16'h0224)); expect_wr(32'h224, 32'h0000_8005);
        emit(enc_r(F_AND, 9, 2, 10));
        emit(enc_i(OP_SW, 0, 10, 16'h0228)); expect_wr(32'h228, 32'd6);
        emit(enc_r(F_ADD, 5, 6, 13));
        emit(enc_i(OP_SW, 0, 13, 16'h022C)); expect_wr(32'h22C, 32'd0);
        emit(enc_i(OP_BEQ, 1, 2, 16'd5));     // 0x6C: not taken
        emit(enc_i(OP_BEQ, 1, 1, 16'd1));     // 0x70: taken, skips next
        emit(enc_i(OP_SW, 0, 1, 16'h0230));   // skipped
        emit(enc_j(26'h0000040));             // 0x78: -> 0x100
        pidx = 64;
        emit(32'hFC00_0000);
        release_reset(rc[0]);
        for (int n = 1; n <= 30; n++) wait_retired(n, rc[n], pcs[n]);
        check("lat_addi_first", rc[1] - rc[0], 32'd4);
        check("lat_add", rc[3] - rc[2], 32'd4);
        check("pc_after_add", pcs[3], 32'd12);
        check("lat_sw", rc[4] - rc[3], 32'd4);
        check("lat_lw", rc[5] - rc[4], 32'd5);
        check("lat_beq_nt", rc[28] - rc[27], 32'd3);
        check("pc_beq_nt", pcs[28], 32'h70);
        check("lat_beq_t", rc[29] - rc[28], 32'd3);
        check("pc_beq_t", pcs[29], 32'h78);
        check("lat_j", rc[30] - rc[29], 32'd2);
        check("pc_j", pcs[30], 32'h100);
        wait_halt();
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (memReq_out || (retired_out != 32'd30) || !halted_out) bad++;
        end
        check("halt_quiet_cycles_bad", bad, 32'd0);
        check("halt_retired", retired_out, 32'd30);
        check("halt_pc", pc_out, 32'h104);
        check("sbA_empty", sb.size(), 32'd0);

        // Program B: three wait cycles per memory access.
        new_program(3);
        emit(enc_j(26'h0000010));
        pidx = 16;
        emit(enc_i(OP_ADDI, 0, 3, 16'd12));
        emit(enc_i(OP_SW, 0, 3, 16'd8));     expect_wr(32'h8, 32'd12);
        emit(enc_i(OP_LW, 0, 4, 16'd8));
        emit(enc_i(OP_SW, 0, 4, 16'd12));    expect_wr(32'hC, 32'd12);
        emit(32'hFC00_0000);
        release_reset(rc[0]);
        for (int n = 1; n <= 5; n++) wait_retired(n, rc[n], pcs[n]);
        check("w3_lat_j", rc[1] - rc[0], 32'd5);
        check("w3_lat_addi", rc[2] - rc[1], 32'd7);
        check("w3_lat_sw", rc[3] - rc[2], 32'd10);
        check("w3_lat_lw", rc[4] - rc[3], 32'd11);
        check("w3_sw_lw_total", rc[4] - rc[2], 32'd21);
        wait_halt();
        check("sbB_empty", sb.size(), 32'd0);

        // Program C: beq self loop.
        new_program(0);
        emit(enc_i(OP_ADDI, 0, 1, 16'd3));
        emit(enc_i(OP_BEQ, 1, 1, 16'hFFFF));
        release_reset(rc[0]);
        for (int n = 1; n <= 3; n++) wait_retired(n, rc[n], pcs[n]);
        check("loop_lat", rc[2] - rc[1], 32'd3);
        check("loop_pc1", pcs[2], 32'd4);
        check("loop_pc2", pcs[3], 32'd4);

        // Program D: reset while a store sits in MEM.
        new_program(5);
        emit(enc_i(OP_ADDI, 0, 2, 16'h0055));
        emit(enc_i(OP_SW, 0, 2, 16'h0080));  expect_wr(32'h80, 32'h55);
        emit(32'hFC00_0000);
        release_reset(rc[0]);
        wait_retired(1, rc[1], pcs[1]);
        bad = 1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (memReq_out && memWe_out) begin
                bad = 0;
                break;
            end
        end
        check("reached_mem", bad, 32'd0);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_req", {31'd0, memReq_out}, 32'd0);
        check("mid_rst_we", {31'd0, memWe_out}, 32'd0);
        check("mid_rst_addr", memAddr_out, 32'd0);
        check("mid_rst_wdata", memWData_out, 32'd0);
        check("mid_rst_pc", pc_out, 32'd0);
        check("mid_rst_retired", retired_out, 32'd0);
        release_reset(rc[0]);
        bad = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (memReq_out) begin
                bad = 0;
                break;
            end
        end
        check("restart_req_seen", bad, 32'd0);
        check("restart_addr", memAddr_out, 32'd0);
        wait_retired(1, rc[1], pcs[1]);
        wait_retired(2, rc[2], pcs[2]);
        check("restart_pc", pcs[2], 32'd8);
        wait_halt();
        check("sbD_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
